// File: rtl/addr_gen_fwd_gate.sv
// addr_gen_fwd_gate: generates activation RAM write addresses for NUM_GATE gate streams.
module addr_gen_fwd_gate #(
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_CELL    = 8,
  parameter int NUM_INPUT   = 53,
  parameter int TIMESTEP    = 7,
  parameter int DELAY       = 2,
  parameter int NUM_GATE    = 4,
  parameter int GATE_STRIDE = NUM_CELL * TIMESTEP,
  parameter int REVERSE     = 0,
  localparam int GW = NUM_GATE > 1 ? $clog2(NUM_GATE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [GW-1:0]         o_gate,
  output logic                  o_we,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int AW = ADDR_WIDTH;
  localparam int IW = NUM_INPUT > 1 ? $clog2(NUM_INPUT) : 1;
  localparam int DW = DELAY > 1 ? $clog2(DELAY) : 1;
  localparam int CW = NUM_CELL > 1 ? $clog2(NUM_CELL) : 1;
  localparam int TW = TIMESTEP > 1 ? $clog2(TIMESTEP) : 1;
  localparam logic [TW-1:0] TS_FIRST = REVERSE != 0 ? TW'(TIMESTEP - 1) : '0;
  localparam logic [TW-1:0] TS_LAST  = REVERSE != 0 ? '0 : TW'(TIMESTEP - 1);
  localparam logic [AW-1:0] TB_FIRST = REVERSE != 0 ? AW'((TIMESTEP - 1) * NUM_CELL) : '0;
  typedef enum logic [2:0] {IDLE, ACC, WAIT, WRITE, DONE} state_e;
  state_e          state_q, state_d;
  logic [IW-1:0]   in_q, in_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [CW-1:0]   cell_q, cell_d;
  logic [TW-1:0]   ts_q, ts_d;
  logic [GW-1:0]   g_q, g_d;
  logic [AW-1:0]   ts_base_q, ts_base_d, gate_base_q, gate_base_d;
  logic [AW-1:0]   o_addr_d;
  logic [GW-1:0]   o_gate_d;
  logic            o_we_d, o_busy_d, o_done_d;
  // ts_base tracks ts*NUM_CELL and gate_base tracks g*GATE_STRIDE, so no multiplier is needed
  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    dly_d       = dly_q;
    cell_d      = cell_q;
    ts_d        = ts_q;
    g_d         = g_q;
    ts_base_d   = ts_base_q;
    gate_base_d = gate_base_q;
    o_addr_d    = o_addr;
    o_gate_d    = o_gate;
    o_busy_d    = o_busy;
    o_we_d      = 1'b0;
    o_done_d    = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: if (start) begin
          state_d   = ACC;
          in_d      = '0;
          cell_d    = '0;
          ts_d      = TS_FIRST;
          ts_base_d = TB_FIRST;
        end
        ACC: begin
          in_d = in_q + 1'b1;
          if (in_q == IW'(NUM_INPUT - 1)) begin
            in_d        = '0;
            dly_d       = '0;
            g_d         = '0;
            gate_base_d = '0;
            state_d     = DELAY == 0 ? WRITE : WAIT;
          end
        end
        WAIT: begin
          dly_d = dly_q + 1'b1;
          if (dly_q == DW'(DELAY - 1)) begin
            dly_d   = '0;
            state_d = WRITE;
          end
        end
        WRITE: begin
          g_d         = g_q + 1'b1;
          gate_base_d = gate_base_q + AW'(GATE_STRIDE);
          if (g_q == GW'(NUM_GATE - 1)) begin
            g_d         = '0;
            gate_base_d = '0;
            state_d     = ACC;
            cell_d      = cell_q + 1'b1;
            if (cell_q == CW'(NUM_CELL - 1)) begin
              cell_d    = '0;
              ts_d      = REVERSE != 0 ? ts_q - 1'b1 : ts_q + 1'b1;
              ts_base_d = REVERSE != 0 ? ts_base_q - AW'(NUM_CELL) : ts_base_q + AW'(NUM_CELL);
              state_d   = ts_q == TS_LAST ? DONE : ACC;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
      o_we_d   = state_q == WRITE;
      o_done_d = state_q == DONE;
      o_busy_d = state_q == ACC || state_q == WAIT || state_q == WRITE;
      o_addr_d = state_q == WRITE ? gate_base_q + ts_base_q + AW'(cell_q) : o_addr;
      o_gate_d = state_q == WRITE ? g_q : o_gate;
    end
    if (clr) begin
      state_d     = IDLE;
      in_d        = '0;
      dly_d       = '0;
      cell_d      = '0;
      ts_d        = '0;
      g_d         = '0;
      ts_base_d   = '0;
      gate_base_d = '0;
      o_addr_d    = '0;
      o_gate_d    = '0;
      o_we_d      = 1'b0;
      o_busy_d    = 1'b0;
      o_done_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_q        <= '0;
      dly_q       <= '0;
      cell_q      <= '0;
      ts_q        <= '0;
      g_q         <= '0;
      ts_base_q   <= '0;
      gate_base_q <= '0;
      o_addr      <= '0;
      o_gate      <= '0;
      o_we        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      dly_q       <= dly_d;
      cell_q      <= cell_d;
      ts_q        <= ts_d;
      g_q         <= g_d;
      ts_base_q   <= ts_base_d;
      gate_base_q <= gate_base_d;
      o_addr      <= o_addr_d;
      o_gate      <= o_gate_d;
      o_we        <= o_we_d;
      o_busy      <= o_busy_d;
      o_done      <= o_done_d;
    end
  end
endmodule
